hls_deadlock_report_ctrl: RTL
=============================

Name: hls_deadlock_report_ctrl

Overview:
- Collects the `block` outputs of the per-instance HLS deadlock monitors (for example the idx0 monitor of v_tpg_inst and its siblings).
- Qualifies each one by persistence, so that transient back-pressure is not reported as deadlock.
- Latches confirmed deadlocks as sticky events with a timestamp.
- Round-robin schedules the events onto a single valid/ready report channel read by the debug/AXI-lite status logic.

Parameters:
- NUM_SRC, 4: number of monitor `block` inputs; legal range 1..16.
- THRESH, 1024: consecutive high cycles required to confirm a deadlock; must be >= 1.
- TS_W, 32: width of the free-running timestamp counter.
- SRC_W, $clog2(NUM_SRC) with minimum 1: width of the source index (derived, not overridable).

Ports:
- clock, in, 1: single clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high.
- block_sigs, in, NUM_SRC: raw `block` outputs of the monitors.
- clear, in, 1: single-cycle pulse that flushes all events.
- report_valid, out, 1: a report is offered.
- report_ready, in, 1: the consumer accepts the report.
- report_src, out, SRC_W: index of the reporting source.
- report_ts, out, TS_W: timestamp at which the deadlock was confirmed.
- pending, out, NUM_SRC: confirmed but not yet reported.
- reported, out, NUM_SRC: reported and still blocked (suppresses re-report).
- any_deadlock, out, 1: OR of pending and reported.

Behaviour:
- Reset, synchronous: all outputs are 0, all counters are 0, timestamp is 0, FSM is in IDLE, and the round-robin pointer `last` = NUM_SRC-1 (so the first grant goes to source 0).
- Timestamp: `ts` increments every cycle and wraps from 2^TS_W-1 to 0 with no flag.

Persistence filter (per source i):
- cnt[i] has width $clog2(THRESH+1).
- If block_sigs[i]=0, cnt[i] <= 0.
- Else cnt[i] <= min(cnt[i]+1, THRESH).
- The filter confirms at the edge where cnt[i] == THRESH-1 and block_sigs[i]=1.
- On confirmation, if pending[i]=0 and reported[i]=0: pending[i] <= 1 and ts_cap[i] <= ts (the pre-increment value).
- Result: block_sigs[i] high for THRESH consecutive edges starting at edge E0 sets pending[i] after edge E0+THRESH-1.

Flag lifetime:
- pending[i] is sticky. It does not clear when block_sigs[i] falls; a confirmed event is always reported.
- reported[i] is set on the handshake for source i.
- reported[i] clears when block_sigs[i]=0 is sampled, which re-arms the source. A later persistent block then produces a new report.

FSM:
- IDLE: if |pending, select the first set bit scanning from last+1 upward with wrap. Load report_src and report_ts from ts_cap, then go to SEND. Otherwise stay in IDLE.
- SEND: report_valid=1. report_src and report_ts are held stable until the handshake.
- Handshake: on report_valid & report_ready, clear pending[sel], set reported[sel] (or leave it clear if block_sigs[sel]=0 in the same cycle), set last <= sel, and go to IDLE.
- Throughput is at most one report per 2 cycles. Latency from pending set to report_valid is 1 cycle when the FSM is idle.

Simultaneous events and corner cases:
- Confirmation of source j during SEND of source i: pending[j] is set and served after return to IDLE.
- Confirmation and handshake of the same source in one cycle cannot occur, because pending gates confirmation.
- clear (and reset) has priority over everything:
  - pending, reported and cnt go to 0 and the FSM goes to IDLE; `ts` and `last` are unaffected by clear.
  - report_valid drops on the next edge even mid-SEND. This is the only permitted abort of a valid.
  - A report_ready coinciding with clear is ignored.
- THRESH=1: confirmation happens on the first high edge.
- The counter saturates at THRESH, so a long block does not wrap and cause a re-confirmation.

any_deadlock is combinational from registered flags, so it has no extra latency.

Decomposition:
- Package hls_deadlock_pkg holds:
  - the FSM state enum (IDLE, SEND);
  - a helper function that computes SRC_W;
  - the round-robin first-set-bit search function, shared with future arbiters.
- Sub-module hls_deadlock_persist_filter, one instance per source:
  - contains the counter and the confirm pulse;
  - parameter THRESH; ports clock, reset, clear, blk, confirm.

Test Plan (NUM_SRC=4, THRESH=4, TS_W=8 unless stated):
1. Reset then idle 20 cycles → all outputs 0; report_valid is never asserted.
2. block_sigs[2] high for 3 edges then low → no pending. Then high for 4 edges starting at ts=10 → pending=4'b0100 after edge ts=13, report_valid after the next edge with report_src=2, report_ts=13. With ready high, reported[2]=1; after block_sigs[2] drops, reported clears.
3. block_sigs = 4'b1011 rise together, report_ready held low for 10 cycles, then high → reports in order src 0, 1, 3, every other cycle. report_src and report_ts stay stable while ready is low.
4. Source 1 blocked continuously for 50 cycles → exactly one report. Drop for 1 cycle, re-block for 4 → a second report with a new timestamp.
5. clear asserted while report_valid=1 with ready=0 and 2 pending → next cycle report_valid=0, pending=0, reported=0, any_deadlock=0. A subsequent 4-cycle block is reported normally.
6. TS_W=4, confirm at ts=15 → report_ts=15, then the next event reports a wrapped value, e.g. 2. Also run THRESH=1: a one-cycle block gives a report 1 cycle later.

Source files
------------

// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS deadlock reporting block.
package hls_deadlock_pkg;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   // Width of a source index; a single source still needs one bit.
   function automatic int unsigned src_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Round-robin search: first set bit of req[n-1:0] scanning upward from last+1 with wrap.
   // Returns last when no bit is set.
   function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                          input logic [3:0]  last,
                                          input int unsigned n);
      logic        found;
      logic [3:0]  pick;
      int unsigned j;
      found = 1'b0;
      pick  = last;
      for (int unsigned k = 1; k <= 16; k++) begin
         if (k <= n) begin
            j = int'(last) + k;
            if (j >= n) j = j - n;
            if (!found && req[4'(j)]) begin
               found = 1'b1;
               pick  = 4'(j);
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/hls_deadlock_persist_filter.sv
// Persistence filter: confirms a monitor block signal after THRESH consecutive high edges.
module hls_deadlock_persist_filter #(
   parameter int unsigned THRESH = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic blk,
   output logic confirm
);

   localparam int unsigned CW = $clog2(THRESH + 1);

   logic [CW-1:0] cnt;

   // Count consecutive high cycles, saturating at THRESH so a long block cannot re-confirm.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (!blk) begin
         cnt <= '0;
      end else if (cnt != CW'(THRESH)) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign confirm = blk && !clear && (cnt == CW'(THRESH - 1));

endmodule

// File: rtl/hls_deadlock_report_ctrl.sv
// Collects per-instance deadlock monitor outputs, latches confirmed events with a
// timestamp and reports them round-robin over one valid/ready channel.
module hls_deadlock_report_ctrl
   import hls_deadlock_pkg::*;
#(
   parameter  int unsigned NUM_SRC = 4,
   parameter  int unsigned THRESH  = 1024,
   parameter  int unsigned TS_W    = 32,
   localparam int unsigned SRC_W   = src_width(NUM_SRC)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] block_sigs,
   input  logic               clear,
   output logic               report_valid,
   input  logic               report_ready,
   output logic [SRC_W-1:0]   report_src,
   output logic [TS_W-1:0]    report_ts,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] reported,
   output logic               any_deadlock
);

   state_t             state;
   state_t             state_nx;
   logic               hs;
   logic [TS_W-1:0]    ts;
   logic [TS_W-1:0]    ts_cap [NUM_SRC];
   logic [SRC_W-1:0]   last;
   logic [NUM_SRC-1:0] confirm;
   logic [NUM_SRC-1:0] new_evt;
   logic [15:0]        req;
   logic [SRC_W-1:0]   sel;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_filt
      hls_deadlock_persist_filter #(.THRESH(THRESH)) u_filt (
         .clock   (clock),
         .reset   (reset),
         .clear   (clear),
         .blk     (block_sigs[g]),
         .confirm (confirm[g])
      );
   end

   assign new_evt      = confirm & ~pending & ~reported;
   assign report_valid = (state == SEND);
   assign any_deadlock = |(pending | reported);

   // Round-robin choice among pending sources, starting after the last one served.
   always_comb begin
      req                = '0;
      req[NUM_SRC-1:0]   = pending;
      sel                = SRC_W'(rr_pick(req, 4'(last), NUM_SRC));
   end

   // Free-running timestamp, wraps silently.
   always_ff @(posedge clock) begin
      if (reset) ts <= '0;
      else       ts <= ts + TS_W'(1);
   end

   // FSM state register; clear aborts a pending offer.
   always_ff @(posedge clock) begin
      if (reset || clear) state <= IDLE;
      else                state <= state_nx;
   end

   // Next-state and handshake detection.
   always_comb begin
      state_nx = state;
      hs       = 1'b0;
      case (state)
         IDLE: if (|pending) state_nx = SEND;
         SEND: begin
            if (report_ready) begin
               hs       = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Report payload is loaded on leaving IDLE and held through SEND.
   always_ff @(posedge clock) begin
      if (reset) begin
         report_src <= '0;
         report_ts  <= '0;
      end else if (state == IDLE && |pending) begin
         report_src <= sel;
         report_ts  <= ts_cap[sel];
      end
   end

   // Round-robin pointer follows the last accepted source; clear leaves it alone.
   always_ff @(posedge clock) begin
      if (reset)            last <= SRC_W'(NUM_SRC - 1);
      else if (hs && !clear) last <= report_src;
   end

   // Capture the confirmation timestamp of each newly latched event.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_SRC; i++) ts_cap[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_SRC; i++)
            if (new_evt[i]) ts_cap[i] <= ts;
      end
   end

   // Event flags: pending is sticky until reported; reported re-arms when the block drops.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         pending  <= '0;
         reported <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (hs && report_src == SRC_W'(i)) begin
               pending[i]  <= 1'b0;
               reported[i] <= block_sigs[i];
            end else begin
               if (new_evt[i])      pending[i]  <= 1'b1;
               if (!block_sigs[i])  reported[i] <= 1'b0;
            end
         end
      end
   end

endmodule
